mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Load/store unit in the MEM stage. It consumes the memory fields that the EX/MEM pipeline register presents (aluop, memory address, reg2, ALU result, excepttype).
- Drives a req/ack data bus, big-endian byte lanes.
- Stalls the pipeline through ctrl until the access completes.
- Returns aligned, extended load data, or passes the ALU result through, toward MEM/WB.

Parameters:
- BUS_AW, 32, data bus address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush from ctrl
- mem_aluop_i  in  8  operation (EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP; anything else is non-memory)
- mem_addr_i  in  32  effective byte address
- mem_reg2_i  in  32  store source register
- mem_wdata_i  in  32  ALU result for non-memory ops
- excepttype_i  in  32  nonzero means the instruction already carries an exception
- bus_req_o  out  1  access request, held until ack
- bus_we_o  out  1  1 = store
- bus_addr_o  out  BUS_AW  word address {addr[31:2],2'b00}
- bus_sel_o  out  4  byte enables, bit3 = byte at offset 0
- bus_wdata_o  out  32  store data, lane-replicated
- bus_ack_i  in  1  one-cycle completion pulse
- bus_rdata_i  in  32  read data, valid with ack
- wdata_o  out  32  result to MEM/WB
- stallreq_o  out  1  stall request to ctrl
- adel_o  out  1  load address error (combinational)
- ades_o  out  1  store address error (combinational)

Behaviour:
- access = memory op AND excepttype_i==0 AND no misalign AND flush==0.
- misalign: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. On misalign:
  - adel_o (loads) or ades_o (stores) = 1.
  - no bus request is issued.
  - wdata_o = 0.
- Byte lanes (big-endian), by offset 0/1/2/3:
  - byte: sel 1000/0100/0010/0001, data rdata[31:24]/[23:16]/[15:8]/[7:0].
  - half: offset 0 gives sel 1100 and [31:16]; offset 2 gives sel 0011 and [15:0].
  - word: sel 1111.
- Store data:
  - SB: {4{reg2[7:0]}}
  - SH: {2{reg2[15:0]}}
  - SW: reg2
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states IDLE, BUSY, DONE, ABORT.
- IDLE:
  - On access: at the next edge go to BUSY and register bus_req_o=1 with we/addr/sel/wdata.
  - stallreq_o = access (combinational).
- BUSY:
  - Outputs hold stable and stallreq_o = 1.
  - On bus_ack_i: capture the formatted load data (0 for stores) into rdata_q, drop req/sel/we, go to DONE.
  - Flush in BUSY without ack: go to ABORT, keeping req asserted.
  - Flush and ack in the same cycle: ack wins the handshake, data is discarded, go to IDLE.
- DONE:
  - Lasts exactly 1 cycle; stallreq_o = 0.
  - wdata_o = rdata_q (loads) or mem_wdata_i (stores).
  - Then go to IDLE unconditionally.
- ABORT:
  - req stays held until ack; the ack is consumed and data discarded, then go to IDLE.
  - stallreq_o = access of the new instruction.
  - The new access starts only after returning to IDLE.
- Outside DONE, wdata_o = mem_wdata_i for non-memory ops.
- Bus latency: min 1 cycle req-to-ack. An access therefore costs at least 2 stall cycles plus the DONE cycle. No second request may issue while one is outstanding.
- Reset (async, any state including BUSY): state IDLE; bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, rdata_q = 0. A bus_ack_i arriving while in IDLE is ignored.

Test Plan:
- LB at addr 0x103, rdata 0x11223380, ack 2 cycles after req -> sel 0001, addr 0x100, stallreq high 3 cycles, DONE wdata_o = 0xFFFFFF80.
- LHU at 0x202, rdata 0x1234ABCD -> sel 0011, wdata_o = 0x0000ABCD; LH at 0x200 with the same data -> 0x00001234.
- SH at 0x302, reg2 0xDEADBEEF -> bus_we_o 1, sel 0011, bus_wdata_o 0xBEEFBEEF, req held until ack, then DONE.
- LW at 0x401 -> adel_o 1, no bus_req_o, stallreq_o 0; SW at 0x402 -> ades_o 1; LW with excepttype_i=0x0000000C -> no access.
- Flush in BUSY, ack 3 cycles later, next instruction an LW at 0x500 -> req held through ABORT; second req only after ack; stallreq asserted for the new LW throughout.
- rst pulsed mid-BUSY -> bus_req_o falls asynchronously, state IDLE; a stale ack afterwards produces no DONE.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Request/acknowledge data bus between the MEM-stage load/store unit and memory.
// Byte lanes are big-endian: sel[3] enables the byte at word offset 0.
interface mem_lsu_if #(
  parameter int BUS_AW = 32
);
  logic              req;
  logic              we;
  logic [BUS_AW-1:0] addr;
  logic [3:0]        sel;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus access per memory instruction,
// stalls the pipeline until it completes and returns aligned, extended load data.
module mem_lsu #(
  parameter int BUS_AW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] excepttype_i,
  mem_lsu_if.master   bus,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_e;

  state_e      state, state_n;
  size_e       sz, sz_q;
  logic        is_load, is_store, sext, misalign, access;
  logic        load_q, sext_q;
  logic [1:0]  off_q;
  logic [3:0]  sel_n;
  logic [31:0] store_data, load_data, rdata_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    sz       = SZ_WORD;
    case (mem_aluop_i)
      EXE_LB_OP:  begin is_load  = 1'b1; sz = SZ_BYTE; sext = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; sz = SZ_BYTE; end
      EXE_LH_OP:  begin is_load  = 1'b1; sz = SZ_HALF; sext = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; sz = SZ_HALF; end
      EXE_LW_OP:  is_load  = 1'b1;
      EXE_SB_OP:  begin is_store = 1'b1; sz = SZ_BYTE; end
      EXE_SH_OP:  begin is_store = 1'b1; sz = SZ_HALF; end
      EXE_SW_OP:  is_store = 1'b1;
      default:    ;
    endcase
  end

  assign misalign = (is_load | is_store) &&
                    ((sz == SZ_HALF && mem_addr_i[0]) ||
                     (sz == SZ_WORD && mem_addr_i[1:0] != 2'b00));
  assign access   = (is_load | is_store) && (excepttype_i == 32'h0) && !misalign && !flush;
  assign adel_o   = is_load  && misalign;
  assign ades_o   = is_store && misalign;

  always_comb begin
    sel_n      = 4'b1111;
    store_data = mem_reg2_i;
    case (sz)
      SZ_BYTE: begin
        sel_n      = 4'b1000 >> mem_addr_i[1:0];
        store_data = {4{mem_reg2_i[7:0]}};
      end
      SZ_HALF: begin
        sel_n      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        store_data = {2{mem_reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Formatting uses the offset/size captured at request time, since the
  // instruction inputs are only guaranteed stable while the pipeline is stalled.
  always_comb begin
    load_data = 32'h0;
    half_v    = off_q[1] ? bus.rdata[15:0] : bus.rdata[31:16];
    case (off_q)
      2'd0:    byte_v = bus.rdata[31:24];
      2'd1:    byte_v = bus.rdata[23:16];
      2'd2:    byte_v = bus.rdata[15:8];
      default: byte_v = bus.rdata[7:0];
    endcase
    if (load_q) begin
      case (sz_q)
        SZ_BYTE: load_data = sext_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        SZ_HALF: load_data = sext_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        default: load_data = bus.rdata;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (access) state_n = BUSY;
      BUSY:    if (bus.ack) state_n = flush ? IDLE : DONE;
               else if (flush) state_n = ABORT;
      DONE:    state_n = IDLE;
      default: if (bus.ack) state_n = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = access;
    wdata_o    = (is_load | is_store) ? 32'h0 : mem_wdata_i;
    case (state)
      BUSY:    stallreq_o = 1'b1;
      DONE: begin
        stallreq_o = 1'b0;
        wdata_o    = load_q ? rdata_q : mem_wdata_i;
      end
      default: ;
    endcase
  end

  // NOTE: the bus-facing registers are reset so no stray request appears after reset; they are not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.sel   <= 4'b0000;
      bus.wdata <= 32'h0;
      rdata_q   <= 32'h0;
      load_q    <= 1'b0;
      sext_q    <= 1'b0;
      sz_q      <= SZ_BYTE;
      off_q     <= 2'b00;
    end else if (state == IDLE && access) begin
      bus.req   <= 1'b1;
      bus.we    <= is_store;
      bus.addr  <= BUS_AW'({mem_addr_i[31:2], 2'b00});
      bus.sel   <= sel_n;
      bus.wdata <= store_data;
      load_q    <= is_load;
      sext_q    <= sext;
      sz_q      <= sz;
      off_q     <= mem_addr_i[1:0];
    end else if ((state == BUSY || state == ABORT) && bus.ack) begin
      bus.req <= 1'b0;
      bus.we  <= 1'b0;
      bus.sel <= 4'b0000;
      if (state_n == DONE) rdata_q <= load_data;
    end
  end

endmodule
